// File: rtl/pattern_generator_stream.sv
// Line/frame test-pattern source on a valid/ready pixel stream with SOL/EOL/EOF markers.
// Modes: gray counter, constant, checkerboard, 2-D ramp and vertical bars.
module pattern_generator_stream #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LINE_LEN  = 1290,
  parameter int unsigned NUM_LINES = 24,
  parameter int unsigned BAR_W     = 162
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_sync,
  input  logic              sync,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  input  logic [2:0]        cell_log2,
  input  logic [DATA_W-1:0] delta_x,
  input  logic [DATA_W-1:0] delta_y,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy
);

  localparam int unsigned X_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned Y_W  = $clog2(NUM_LINES + 1);
  localparam int unsigned BC_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_W-1:0]  X_LAST  = X_W'(LINE_LEN - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(NUM_LINES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BAR_W - 1);

  localparam logic [2:0] M_OFF   = 3'd0;
  localparam logic [2:0] M_GRAY  = 3'd1;
  localparam logic [2:0] M_CONST = 3'd2;
  localparam logic [2:0] M_CBW   = 3'd3;
  localparam logic [2:0] M_CBB   = 3'd4;
  localparam logic [2:0] M_RAMP  = 3'd5;
  localparam logic [2:0] M_BARS  = 3'd6;
  localparam logic [2:0] M_RSVD  = 3'd7;

  typedef enum logic [1:0] {IDLE, START, ACTIVE, WAIT_SYNC} state_t;

  state_t            state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [DATA_W-1:0] line_base;
  logic [DATA_W-1:0] acc;
  logic [BC_W-1:0]   bar_cnt;
  logic [2:0]        bar_idx;

  logic [2:0]        mode_q;
  logic [DATA_W-1:0] const_q;
  logic [2:0]        cell_q;
  logic [DATA_W-1:0] dx_q;
  logic [DATA_W-1:0] dy_q;

  logic [2:0]        sel_mode;
  logic [DATA_W-1:0] sel_const;
  logic [2:0]        sel_cell;
  logic [X_W-1:0]    x_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [BC_W-1:0]   bar_cnt_nxt;
  logic [2:0]        bar_idx_nxt;
  logic [X_W-1:0]    xs;
  logic [Y_W-1:0]    ys;
  logic              cb_bit;
  logic [DATA_W-1:0] data_nxt;
  logic              sol_nxt;
  logic              eol_nxt;
  logic              eof_nxt;

  // Next pixel: first pixel of a line in START (using live config), else the successor of x
  always_comb begin
    sel_mode    = mode_q;
    sel_const   = const_q;
    sel_cell    = cell_q;
    x_nxt       = x + X_W'(1);
    acc_nxt     = acc + dx_q;
    bar_cnt_nxt = bar_cnt + BC_W'(1);
    bar_idx_nxt = bar_idx;
    if (bar_cnt == BC_LAST) begin
      bar_cnt_nxt = '0;
      if (bar_idx != 3'd7) bar_idx_nxt = bar_idx + 3'd1;
    end
    if (state == START) begin
      sel_mode    = mode;
      sel_const   = const_val;
      sel_cell    = cell_log2;
      x_nxt       = '0;
      acc_nxt     = line_base;
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
    end
    xs     = x_nxt >> sel_cell;
    ys     = y >> sel_cell;
    cb_bit = xs[0] ^ ys[0];
    case (sel_mode)
      M_GRAY:  data_nxt = DATA_W'(x_nxt ^ (x_nxt >> 1));
      M_CONST: data_nxt = sel_const;
      M_CBW:   data_nxt = cb_bit ? '1 : '0;
      M_CBB:   data_nxt = cb_bit ? '0 : '1;
      M_RAMP:  data_nxt = acc_nxt;
      M_BARS:  data_nxt = {bar_idx_nxt, (DATA_W-3)'(0)};
      default: data_nxt = '0;
    endcase
    sol_nxt = (x_nxt == '0);
    eol_nxt = (x_nxt == X_LAST);
    eof_nxt = eol_nxt && (y == Y_LAST);
  end

  // Control FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      acc       <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      mode_q    <= '0;
      const_q   <= '0;
      cell_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_sol   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (f_sync && sync) begin
            state     <= START;
            busy      <= 1'b1;
            y         <= '0;
            line_base <= '0;
          end
        end
        START: begin
          mode_q  <= mode;
          const_q <= const_val;
          cell_q  <= cell_log2;
          dx_q    <= delta_x;
          dy_q    <= delta_y;
          x       <= x_nxt;
          acc     <= acc_nxt;
          bar_cnt <= bar_cnt_nxt;
          bar_idx <= bar_idx_nxt;
          if (mode == M_OFF || mode == M_RSVD) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= ACTIVE;
            pix_valid <= 1'b1;
            pix_data  <= data_nxt;
            pix_sol   <= sol_nxt;
            pix_eol   <= eol_nxt;
            pix_eof   <= eof_nxt;
          end
        end
        ACTIVE: begin
          // End of line by EOL transfer or abort; an aborted line still counts
          if ((pix_ready && pix_eol) || sync) begin
            y         <= y + Y_W'(1);
            line_base <= line_base + dy_q;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sol   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            if (y == Y_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (pix_ready && pix_eol) begin
              state <= WAIT_SYNC;
            end else begin
              state <= START;
            end
          end else if (pix_ready) begin
            x        <= x_nxt;
            acc      <= acc_nxt;
            bar_cnt  <= bar_cnt_nxt;
            bar_idx  <= bar_idx_nxt;
            pix_data <= data_nxt;
            pix_sol  <= sol_nxt;
            pix_eol  <= eol_nxt;
            pix_eof  <= eof_nxt;
          end
        end
        WAIT_SYNC: begin
          if (sync) state <= START;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_generator_stream.sv
// Scoreboard bench for pattern_generator_stream: driver pushes expected pixels from a
// coordinate-based reference model, a negedge monitor pops and compares on each transfer.
module tb_pattern_generator_stream;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned LINE_LEN  = 8;
  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned BAR_W     = 2;
  localparam int          MASK      = (1 << DATA_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sol;
    logic              eol;
    logic              eof;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_sync;
  logic              sync;
  logic [2:0]        mode;
  logic [DATA_W-1:0] const_val;
  logic [2:0]        cell_log2;
  logic [DATA_W-1:0] delta_x;
  logic [DATA_W-1:0] delta_y;
  logic              pix_ready;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sol;
  logic              pix_eol;
  logic              pix_eof;
  logic              busy;

  pattern_generator_stream #(
    .DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .NUM_LINES(NUM_LINES), .BAR_W(BAR_W)
  ) dut (
    .clk(clk), .rst(rst), .f_sync(f_sync), .sync(sync), .mode(mode),
    .const_val(const_val), .cell_log2(cell_log2), .delta_x(delta_x), .delta_y(delta_y),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    fm, fcv, fcl, fdx, fdy;
  bit    pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference pixel at (x,y) from the frame config, computed directly from coordinates
  function automatic beat_t model(int x, int y);
    beat_t b;
    int    v, p, bi;
    case (fm)
      1: v = x ^ (x >> 1);
      2: v = fcv;
      3, 4: begin
        p = ((x >> fcl) ^ (y >> fcl)) & 1;
        v = ((p == 1) != (fm == 4)) ? MASK : 0;
      end
      5: v = y * fdy + x * fdx;
      6: begin
        bi = x / BAR_W;
        if (bi > 7) bi = 7;
        v = bi << (DATA_W - 3);
      end
      default: v = 0;
    endcase
    b.data = DATA_W'(v & MASK);
    b.sol  = (x == 0);
    b.eol  = (x == LINE_LEN - 1);
    b.eof  = b.eol && (y == NUM_LINES - 1);
    return b;
  endfunction

  // Monitor: stalled beats must match the queue head, transfers pop it
  always @(negedge clk) begin
    beat_t act;
    if (!rst && pix_valid) begin
      act = {pix_data, pix_sol, pix_eol, pix_eof};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel actual=%h required=none t=%0t", act, $time);
      end else begin
        if (act != exp_q[0]) begin
          failures++;
          $display("FAIL %s_pixel actual data=%h sol=%b eol=%b eof=%b required data=%h sol=%b eol=%b eof=%b t=%0t",
                   pix_ready ? "xfer" : "stall", act.data, act.sol, act.eol, act.eof,
                   exp_q[0].data, exp_q[0].sol, exp_q[0].eol, exp_q[0].eof, $time);
        end
        if (pix_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg();
    mode      = 3'(fm);
    const_val = DATA_W'(fcv);
    cell_log2 = 3'(fcl);
    delta_x   = DATA_W'(fdx);
    delta_y   = DATA_W'(fdy);
  endtask

  task automatic scramble_cfg();
    mode      = 3'($urandom);
    const_val = DATA_W'($urandom);
    cell_log2 = 3'($urandom);
    delta_x   = DATA_W'($urandom);
    delta_y   = DATA_W'($urandom);
  endtask

  function automatic logic next_ready(int rmode, int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return pat[cyc % 6];
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_line(int y, bit first, bit need_sync, int abort_at, int rmode);
    int n, cnt, cyc, gap;
    bit ab, done;
    n = (abort_at >= 0) ? abort_at + 1 : LINE_LEN;
    for (int x = 0; x < n; x++) exp_q.push_back(model(x, y));
    drive_cfg();
    if (need_sync) begin
      if (!first) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("wait_valid", pix_valid, 0);
          check("wait_busy", busy, 1);
          tick();
        end
      end
      f_sync = first ? 1'b1 : 1'($urandom_range(0, 1));
      sync   = 1'b1;
      tick();
      f_sync = 1'b0;
      sync   = 1'b0;
    end
    @(negedge clk);
    check("start_valid", pix_valid, 0);
    check("start_busy", busy, 1);
    tick();
    scramble_cfg();
    cnt = 0; cyc = 0; ab = 1'b0; done = 1'b0;
    while (!done) begin
      if (abort_at >= 0 && cnt == abort_at) begin
        pix_ready = 1'b0;
        sync      = 1'b1;
        ab        = 1'b1;
      end else begin
        pix_ready = next_ready(rmode, cyc);
      end
      @(negedge clk);
      check("active_valid", pix_valid, 1);
      if (pix_valid && pix_ready) cnt++;
      tick();
      sync = 1'b0;
      cyc++;
      if (ab || cnt == LINE_LEN) begin
        done = 1'b1;
      end else if (cyc > 200) begin
        check("line_timeout", cnt, LINE_LEN);
        done = 1'b1;
      end
    end
    pix_ready = 1'b0;
    drive_cfg();
    if (ab) begin
      check("abort_residue", exp_q.size(), 1);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(int m, int cv, int cl, int dx, int dy, int rmode,
                           int abort_line, int abort_at);
    bit need_sync;
    fm = m; fcv = cv; fcl = cl; fdx = dx; fdy = dy;
    need_sync = 1'b1;
    for (int y = 0; y < NUM_LINES; y++) begin
      run_line(y, y == 0, need_sync, (y == abort_line) ? abort_at : -1, rmode);
      need_sync = (y != abort_line);
    end
    @(negedge clk);
    check("frame_end_valid", pix_valid, 0);
    check("frame_end_busy", busy, 0);
    check("frame_queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_off_frame(int m);
    int vcnt;
    fm = m; fcv = 0; fcl = 0; fdx = 0; fdy = 0;
    drive_cfg();
    f_sync = 1'b1;
    sync   = 1'b1;
    tick();
    f_sync = 1'b0;
    sync   = 1'b0;
    @(negedge clk);
    check("off_start_busy", busy, 1);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pix_valid) vcnt++;
    end
    check("off_valid_count", vcnt, 0);
    check("off_busy", busy, 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"}, pix_data, 0);
    check({tag, "_sol"}, pix_sol, 0);
    check({tag, "_eol"}, pix_eol, 0);
    check({tag, "_eof"}, pix_eof, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; f_sync = 1'b0; sync = 1'b0; pix_ready = 1'b0;
    fm = 1; fcv = 0; fcl = 0; fdx = 0; fdy = 0;
    drive_cfg();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("por");

    // Reset in the middle of an active line drops the partial line
    for (int x = 0; x < LINE_LEN; x++) exp_q.push_back(model(x, 0));
    f_sync = 1'b1; sync = 1'b1;
    tick();
    f_sync = 1'b0; sync = 1'b0; pix_ready = 1'b1;
    repeat (3) tick();
    pix_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    exp_q.delete();

    run_frame(1, 0, 0, 0, 0, 0, -1, 0);          // gray, always ready
    run_frame(1, 0, 0, 0, 0, 1, -1, 0);          // gray, backpressure pattern
    run_frame(4, 0, 1, 0, 0, 0, -1, 0);          // cb_black, 2x2 cells
    run_frame(3, 0, 0, 0, 0, 2, -1, 0);          // cb_white, 1x1 cells
    run_frame(5, 0, 0, 4, 16, 0, -1, 0);         // ramp
    run_frame(5, 0, 0, 'hFFF, 'h123, 1, -1, 0);  // ramp with wrap
    run_frame(6, 0, 0, 0, 0, 0, -1, 0);          // bars
    run_frame(2, 'hA5C, 0, 0, 0, 2, -1, 0);      // constant
    run_frame(5, 0, 0, 4, 16, 0, 1, 3);          // abort line 1 after 3 pixels
    run_frame(1, 0, 0, 0, 0, 2, 3, 5);           // abort on the last line
    run_off_frame(0);
    run_off_frame(7);

    for (int f = 0; f < 20; f++) begin
      int al;
      al = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, NUM_LINES - 1)) : -1;
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(0, MASK)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
                int'($urandom_range(0, MASK)), 2, al, int'($urandom_range(0, LINE_LEN - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
